seg7_mux_counter: RTL and testbench

SEG7_MUX_COUNTER -- requirements
Module: seg7_mux_counter

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_mux_counter_if.sv | 13 +
 rtl/seg7_decoder.sv | 13 +
 rtl/seg7_mux_counter.sv | 172 +++++++++++++++++
 tb/tb_seg7_mux_counter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment counter.
// Holds the segment table, ui_in bit positions and the 4-bit digit type.
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam int UI_RUN   = 0;
    localparam int UI_DOWN  = 1;
    localparam int UI_CLEAR = 2;
    localparam int UI_HEX   = 3;
    localparam int UI_STEP  = 4;
    localparam int UI_BLANK = 5;
    localparam int SYNC_W   = 6;

    // Segments a..g, bit0 = a, active-high
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_encode(input digit_t v);
        return SEG_TABLE[v];
    endfunction

endpackage

// File: rtl/seg7_mux_counter_if.sv
// Pin-level bundle of the display counter: enable, user inputs and the
// segment/digit outputs; clock and reset are kept outside.
interface seg7_mux_counter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational 4-bit value to seven-segment decoder with a blanking input.
// Zero latency; no flow control.
module seg7_decoder
    import seg7_pkg::*;
(
    input  digit_t     i_val,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    assign o_seg = i_blank ? 7'h00 : seg_encode(i_val);

endmodule

// File: rtl/seg7_mux_counter.sv
// Multi-digit BCD/hex up/down counter driving a time-multiplexed 7-seg display.
// Inputs see 2 cycles of synchroniser latency; outputs are registered; ena=0 stalls everything but the synchronisers.
module seg7_mux_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_COUNT = 10_000_000,
    parameter int SCAN_COUNT = 1000
)
(
    input logic               clk,
    input logic               rst_n,
    seg7_mux_counter_if.slave bus
);

    localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_COUNT - 1);
    localparam logic [SW-1:0]         SCAN_LAST  = SW'(SCAN_COUNT - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);
    localparam logic [7:0]            OE_MASK    = 8'((1 << NUM_DIGITS) - 1);

    logic [SYNC_W-1:0]     r_sync1, r_sync2;
    logic                  r_step_d, r_hex_d;
    logic [1:0]            r_warm;
    logic [PW-1:0]         r_presc;
    logic [CW-1:0]         r_cnt;
    logic                  r_tog;
    logic [SW-1:0]         r_scan;
    logic [IW-1:0]         r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig_n;

    logic          w_run, w_down, w_clear, w_hex, w_step, w_blank;
    logic          w_tick, w_step_rise, w_adv, w_hex_chg;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_carry;
    digit_t        w_dmax;
    digit_t        w_dig;
    logic          w_blk_sel, w_zero_above;
    logic [6:0]    w_seg;
    logic          w_unused;

    assign w_unused = &{1'b0, bus.uio_in, bus.ui_in[7:6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.ui_in[SYNC_W-1:0];
            r_sync2 <= r_sync1;
        end
    end

    assign w_run   = r_sync2[UI_RUN];
    assign w_down  = r_sync2[UI_DOWN];
    assign w_clear = r_sync2[UI_CLEAR];
    assign w_hex   = r_sync2[UI_HEX];
    assign w_step  = r_sync2[UI_STEP];
    assign w_blank = r_sync2[UI_BLANK];

    // Step edges are ignored until the synchroniser and edge register have both
    // seen post-reset data, so a step held through reset cannot fake an edge.
    assign w_tick      = w_run && (r_presc == PRESC_LAST);
    assign w_step_rise = w_step && !r_step_d && (r_warm == 2'd3);
    assign w_adv       = w_tick || w_step_rise;
    assign w_hex_chg   = w_hex ^ r_hex_d;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_carry   = 1'b1;
        w_dmax    = w_hex ? 4'hF : 4'h9;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (w_down) begin
                    if (r_cnt[i*4 +: 4] == 4'h0) begin
                        w_cnt_nxt[i*4 +: 4] = w_dmax;
                    end else begin
                        w_cnt_nxt[i*4 +: 4] = r_cnt[i*4 +: 4] - 4'h1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (r_cnt[i*4 +: 4] == w_dmax) begin
                        w_cnt_nxt[i*4 +: 4] = 4'h0;
                    end else begin
                        w_cnt_nxt[i*4 +: 4] = r_cnt[i*4 +: 4] + 4'h1;
                        w_carry = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_cnt    <= '0;
            r_tog    <= 1'b0;
            r_step_d <= 1'b0;
            r_hex_d  <= 1'b0;
            r_warm   <= 2'd0;
        end else if (bus.ena) begin
            r_step_d <= w_step;
            r_hex_d  <= w_hex;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            if (w_clear) begin
                r_presc <= '0;
                r_cnt   <= '0;
            end else begin
                if (w_run) begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                end
                if (w_hex_chg) begin
                    r_cnt <= '0;
                end else if (w_adv) begin
                    r_cnt <= w_cnt_nxt;
                    r_tog <= ~r_tog;
                end
            end
        end
    end

    // Scanning from the top keeps a running "everything from here up is zero" flag.
    always_comb begin
        w_dig        = '0;
        w_blk_sel    = 1'b0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_cnt[i*4 +: 4] == 4'h0);
            if (r_idx == IW'(i)) begin
                w_dig     = r_cnt[i*4 +: 4];
                w_blk_sel = w_blank && (i != 0) && w_zero_above;
            end
        end
    end

    seg7_decoder u_dec (
        .i_val   (w_dig),
        .i_blank (w_blk_sel),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_idx   <= '0;
            r_seg   <= '0;
            r_dig_n <= '1;
        end else if (bus.ena) begin
            r_seg   <= w_seg;
            r_dig_n <= ~(DIG_ONE << r_idx);
            if (r_scan == SCAN_LAST) begin
                r_scan <= '0;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_scan <= r_scan + SW'(1);
            end
        end
    end

    assign bus.uo_out  = {r_tog, r_seg};
    assign bus.uio_out = 8'(r_dig_n);
    assign bus.uio_oe  = OE_MASK;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Scoreboarded bench: an integer-arithmetic model predicts every registered output
// cycle; directed scenarios add value checks read back from the scanned display.
module tb_seg7_mux_counter;

    localparam int N  = 4;
    localparam int TC = 4;
    localparam int SC = 2;

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
    } sb_t;

    typedef struct {
        string nm;
        int    act;
        int    want;
    } dchk_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg7_mux_counter_if bus();

    seg7_mux_counter #(.NUM_DIGITS(N), .TICK_COUNT(TC), .SCAN_COUNT(SC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sb_t   sbq [$];
    dchk_t dq  [$];
    int    vectors = 0;
    int    errors  = 0;

    // ---------------- reference model ----------------
    bit [5:0]   m_s1, m_s2;
    int         m_cnt, m_presc, m_en, m_warm, m_idx, m_mod;
    bit         m_tog, m_stp, m_hex, m_tick, m_sedge;
    logic [6:0] m_seg;
    logic [3:0] m_an;

    function automatic int modulus(input bit hexm);
        int b = hexm ? 16 : 10;
        int m = 1;
        for (int i = 0; i < N; i++) m = m * b;
        return m;
    endfunction

    function automatic logic [6:0] model_seg(input int idx, input int c, input bit hexm, input bit blk);
        int b = hexm ? 16 : 10;
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * b;
        if (blk && idx > 0 && c < p) return 7'h00;
        return segtab[(c / p) % b];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_cnt = 0; m_presc = 0; m_en = 0; m_warm = 0;
            m_tog = 0; m_stp = 0; m_hex = 0; m_seg = 7'h00; m_an = 4'hF;
        end else begin
            if (bus.ena) begin
                m_idx   = (m_en / SC) % N;
                m_seg   = model_seg(m_idx, m_cnt, m_hex, m_s2[5]);
                m_an    = 4'hF ^ 4'(1 << m_idx);
                m_tick  = m_s2[0] && (m_presc == TC - 1);
                m_sedge = m_s2[4] && !m_stp && (m_warm >= 3);
                if (m_s2[2]) begin
                    m_cnt = 0; m_presc = 0;
                end else begin
                    if (m_s2[0]) m_presc = (m_presc + 1) % TC;
                    if (m_s2[3] != m_hex) begin
                        m_cnt = 0;
                    end else if (m_tick || m_sedge) begin
                        m_mod = modulus(m_s2[3]);
                        m_cnt = m_s2[1] ? (m_cnt + m_mod - 1) % m_mod : (m_cnt + 1) % m_mod;
                        m_tog = !m_tog;
                    end
                end
                m_en = m_en + 1;
                if (m_warm < 3) m_warm = m_warm + 1;
                m_stp = m_s2[4];
                m_hex = m_s2[3];
            end
            m_s2 = m_s1;
            m_s1 = bus.ui_in[5:0];
        end
        sbq.push_back('{uo: {m_tog, m_seg}, uio: {4'h0, m_an}});
    end

    // ---------------- monitor ----------------
    sb_t   mon_e;
    dchk_t mon_d;

    task automatic cmp(input string nm, input int act, input int want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() == 0) begin
            cmp("sb_underflow", 0, 1);
        end else begin
            mon_e = sbq.pop_front();
            if (!rst_n) mon_e = '{uo: 8'h00, uio: 8'h0F};
            cmp("uo_out", int'(bus.uo_out), int'(mon_e.uo));
            cmp("uio_out", int'(bus.uio_out), int'(mon_e.uio));
            cmp("uio_oe", int'(bus.uio_oe), 32'h0F);
        end
        while (dq.size() > 0) begin
            mon_d = dq.pop_front();
            cmp(mon_d.nm, mon_d.act, mon_d.want);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [6:0] rd_seg [N];

    task automatic dchk(input string nm, input int act, input int want);
        dq.push_back('{nm: nm, act: act, want: want});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_step();
        bus.ui_in[4] = 1'b1; cyc(3);
        bus.ui_in[4] = 1'b0; cyc(3);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) pulse_step();
    endtask

    task automatic do_clear();
        bus.ui_in[2] = 1'b1; cyc(3);
        bus.ui_in[2] = 1'b0; cyc(3);
    endtask

    function automatic int seg2val(input logic [6:0] s);
        if (s == 7'h00) return 0;
        for (int i = 0; i < 16; i++) if (segtab[i] == s) return i;
        return -1;
    endfunction

    task automatic expect_count(input string nm, input bit hexm, input int want);
        int v = 0;
        int p = 1;
        for (int d = 0; d < N; d++) rd_seg[d] = 7'h01;
        for (int k = 0; k < 2 * N * SC; k++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++)
                if (bus.uio_out[N-1:0] == (4'hF ^ 4'(1 << d))) rd_seg[d] = bus.uo_out[6:0];
        end
        for (int d = 0; d < N; d++) begin
            v = v + seg2val(rd_seg[d]) * p;
            p = p * (hexm ? 16 : 10);
        end
        dchk(nm, v, want);
    endtask

    // ---------------- directed + random sequence ----------------
    logic [7:0] exp_an  [4] = '{8'h0E, 8'h0D, 8'h0B, 8'h07};
    logic [6:0] exp_seg [4] = '{7'h5B, 7'h66, 7'h00, 7'h00};
    int         toggles;
    bit         prev_tog, found;
    logic [7:0] prev_an;
    logic [31:0] r;

    initial begin
        bus.ena = 1'b1; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
        cyc(3);
        dchk("reset_uo", int'(bus.uo_out), 0);
        dchk("reset_uio", int'(bus.uio_out), 32'h0F);
        rst_n = 1'b1;
        cyc(4);

        // free-running decimal count: 10 ticks in the window
        bus.ui_in[0] = 1'b1;
        toggles = 0; prev_tog = bus.uo_out[7];
        for (int k = 1; k <= 46; k++) begin
            cyc(1);
            if (k == 40) bus.ui_in[0] = 1'b0;
            if (bus.uo_out[7] != prev_tog) toggles++;
            prev_tog = bus.uo_out[7];
        end
        dchk("tick_toggles", toggles, 10);
        expect_count("run_count_10", 1'b0, 10);

        // wrap cases
        do_clear();
        bus.ui_in[1] = 1'b1; cyc(3); pulse_step();
        expect_count("dec_down_wrap", 1'b0, 9999);
        bus.ui_in[1] = 1'b0; cyc(3); pulse_step();
        expect_count("dec_up_wrap", 1'b0, 0);
        bus.ui_in[3] = 1'b1; cyc(4);
        bus.ui_in[1] = 1'b1; cyc(3); pulse_step();
        expect_count("hex_down_wrap", 1'b1, 32'hFFFF);
        dchk("hex_digit0_F", int'(rd_seg[0]), 32'h71);
        bus.ui_in[1] = 1'b0;

        // step edge landing on the same cycle as a tick
        bus.ui_in[3] = 1'b0; cyc(4);
        do_clear();
        bus.ui_in[0] = 1'b1; cyc(3);
        bus.ui_in[4] = 1'b1; cyc(1);
        bus.ui_in[0] = 1'b0; cyc(3);
        bus.ui_in[4] = 1'b0; cyc(3);
        expect_count("tick_step_once", 1'b0, 1);

        // leading-zero blanking scan
        do_clear();
        steps(42);
        bus.ui_in[5] = 1'b1; cyc(3);
        found = 1'b0; prev_an = bus.uio_out;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.uio_out == 8'h0E && prev_an == 8'h07) found = 1'b1;
            else prev_an = bus.uio_out;
        end
        dchk("scan_align", int'(found), 1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            dchk("blank_an", int'(bus.uio_out), int'(exp_an[k/2]));
            dchk("blank_seg", int'(bus.uo_out[6:0]), int'(exp_seg[k/2]));
        end
        bus.ui_in[5] = 1'b0;

        // mode change clears; clear dominates run
        do_clear();
        steps(123);
        expect_count("count_123", 1'b0, 123);
        bus.ui_in[3] = 1'b1; cyc(4);
        expect_count("hex_change_clr", 1'b1, 0);
        steps(3);
        bus.ui_in[2] = 1'b1; bus.ui_in[0] = 1'b1; cyc(10);
        expect_count("clear_with_run", 1'b1, 0);
        bus.ui_in[2] = 1'b0; bus.ui_in[0] = 1'b0; cyc(3);

        // asynchronous reset mid-scan with step held high
        bus.ui_in[3] = 1'b0; cyc(4);
        do_clear();
        steps(57);
        expect_count("count_57", 1'b0, 57);
        bus.ui_in[4] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        dchk("async_rst_uo", int'(bus.uo_out), 0);
        dchk("async_rst_uio", int'(bus.uio_out), 32'h0F);
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        dchk("post_rst_idx0", int'(bus.uio_out), 32'h0E);
        cyc(8);
        expect_count("post_rst_no_adv", 1'b0, 0);
        bus.ui_in[4] = 1'b0; cyc(3);

        // randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            r = $urandom;
            bus.ui_in[0] = r[0] | r[1];
            bus.ui_in[1] = r[2];
            bus.ui_in[2] = (r[7:4] == 4'h0);
            bus.ui_in[3] = bus.ui_in[3] ^ (r[12:8] == 5'h00);
            bus.ui_in[4] = r[13];
            bus.ui_in[5] = r[14];
            bus.ui_in[7:6] = r[16:15];
            bus.uio_in = r[31:24];
            bus.ena = ($urandom_range(0, 9) != 0);
            cyc(1);
        end
        bus.ena = 1'b1;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
